scr1_vmem_dp_banked: RTL and testbench
======================================

// Module: scr1_vmem_dp_banked
// PURPOSE
//  Parametrised dual-port TCM for the RLWE vector extension; next generation of the fixed-LANE DP memory.
//  Port A: scalar instruction fetch. Port B: valid/ready LSU port for scalar byte-enabled or strided, masked vector accesses.
//  Vector ops are sequenced by an FSM, LPC lanes per cycle, so LANE may exceed memory port width.
//  Sits between core LSU/vector unit and the memory; memory array not reset.
// PARAMETERS
//  SCR1_WIDTH   32       word width in bits (multiple of 8)
//  SCR1_SIZE    65536    memory size in bytes (power of 2)
//  SCR1_NBYTES  WIDTH/8  byte lanes per word
//  LANE         8        max vector lanes per op (1..64)
//  LPC          2        lanes served per cycle (power of 2, divides LANE)
//  AW           $clog2(SCR1_SIZE)-2  word address width
// PORTS
//  clk       in   1            clock
//  rst_n     in   1            async active-low reset
//  a_req     in   1            fetch read request
//  a_addr    in   AW           fetch word address
//  a_rvalid  out  1            fetch data valid, 1 cycle after a_req
//  a_rdata   out  WIDTH        fetch data
//  b_req     in   1            LSU request valid
//  b_ready   out  1            LSU request accepted when b_req&b_ready
//  b_we      in   1            1=write 0=read
//  b_vec     in   1            1=vector op, 0=scalar op
//  b_be      in   NBYTES       byte enables, scalar write only
//  b_addr    in   AW           base word address
//  b_stride  in   AW           lane stride in words (vector only)
//  b_vlen    in   $clog2(LANE)+1  active lanes, 0 treated as LANE
//  b_mask    in   LANE         per-lane enable (vector only)
//  b_wdata   in   LANE*WIDTH   lane data; scalar uses lane 0
//  b_rvalid  out  1            completion pulse (read data or write ack)
//  b_rdata   out  LANE*WIDTH   read lanes
//  b_busy    out  1            FSM not IDLE
// BEHAVIOUR
//  Reset: a_rvalid=0, a_rdata=0, b_ready=1, b_rvalid=0, b_rdata=0, b_busy=0, FSM=IDLE.
//   Reset mid-op returns to IDLE; lanes already written stay written; no b_rvalid.
//  Port A: a_req registers ram[a_addr] into a_rdata and sets a_rvalid next cycle; otherwise a_rvalid=0, a_rdata holds.
//  FSM IDLE: b_ready=1. On accept, latch all b_* inputs and go XFER with lane counter=0.
//  FSM XFER: b_ready=0. Lanes cnt..cnt+LPC-1 processed; cnt+=LPC.
//   Leave when cnt>=vlen_eff; vector ops take ceil(vlen_eff/LPC) cycles, scalar ops take 1 cycle.
//  FSM DONE: b_rvalid=1 for exactly 1 cycle, b_rdata valid that cycle, then IDLE. b_ready=0 in DONE.
//   Back-to-back: next accept in the cycle after DONE.
//  Latency: accept at T -> b_rvalid at T+1+ceil(vlen_eff/LPC).
//  Lane address: base + i*stride, truncated to AW bits (wraps modulo depth).
//  Masking: lane i active iff i<vlen_eff && mask[i].
//   Inactive read lanes return 0; inactive write lanes do not modify memory.
//   Scalar op: lane 0 only; mask ignored; write is byte-merged per b_be.
//  Two lanes of one op hitting the same word (stride 0 or wrap): highest lane index wins on write; reads all see pre-op data for that word.
//  A/B same word same cycle: A returns old data (read-before-write).
//  b_rdata is cleared at accept; it holds after DONE until the next accept.
// CONFIGURATION
//  SCR1_VMEM_STRIDE_EN defined: b_stride used as specified.
//  Undefined: b_stride ignored, stride forced to 1 (unit-stride only), lane address = base+i mod depth.
// STRUCTURE
//  scr1_vmem_pkg contains:
//   - typedef vmem_state_e {IDLE,XFER,DONE}
//   - typedef vmem_lanes_t = logic [LANE-1:0][WIDTH-1:0]
//   - localparams for default LANE/LPC
//  Sub-module scr1_vmem_addr_gen: latched base/stride/lane counter -> LPC lane addresses + active flags, combinational.
//  Top: FSM, array, port A, lane write/read muxing.
// TESTING
//  1 Scalar wr addr 0x10 data 0xA5A5_A5A5 be=0101, then rd -> b_rdata[0]=0x00A5_00A5 (mem init 0).
//  2 Vector wr base 0x20 vlen 8 mask FF data lane i=i+1, LPC=2 -> b_rvalid 5 cycles after accept;
//    then fetch 0x20..0x27 via A -> 1..8.
//  3 Strided rd base 0x3FFE stride 3 vlen 4 (AW=14) -> addresses 0x3FFE,0x0001,0x0004,0x0007 (wrap).
//    Without SCR1_VMEM_STRIDE_EN -> 0x3FFE,0x3FFF,0x0000,0x0001.
//  4 Masked vector wr mask 0x0F vlen 6 -> only lanes 0-3 written; rd vlen 6 mask 0x30 -> lanes 0-3 and 6-7 zero.
//  5 A fetch 0x40 same cycle B scalar wr 0x40 -> a_rdata old value; next fetch new value.
//  6 Assert rst_n=0 in XFER of vlen 8 op -> b_ready=1, b_busy=0, no b_rvalid; following op completes normally.

Source files
------------

// File: rtl/scr1_vmem_pkg.sv
// Shared types and defaults for the banked dual-port vector TCM.
package scr1_vmem_pkg;

   localparam int SCR1_VMEM_WIDTH_DEF = 32;
   localparam int SCR1_VMEM_LANE_DEF  = 8;
   localparam int SCR1_VMEM_LPC_DEF   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } vmem_state_e;

   typedef logic [SCR1_VMEM_LANE_DEF-1:0][SCR1_VMEM_WIDTH_DEF-1:0] vmem_lanes_t;

endpackage

// File: rtl/scr1_vmem_addr_gen.sv
// Lane address generator: turns the latched base/stride/lane counter into
// LPC word addresses plus per-lane active flags for the current XFER cycle.
// SCR1_VMEM_STRIDE_EN: when defined b_stride is honoured, otherwise unit stride.
module scr1_vmem_addr_gen
   import scr1_vmem_pkg::*;
#(
   parameter int AW   = 14,
   parameter int LANE = SCR1_VMEM_LANE_DEF,
   parameter int LPC  = SCR1_VMEM_LPC_DEF,
   parameter int VW   = $clog2(LANE) + 1,
   parameter int CW   = VW + 1,
   parameter int LIW  = (LANE > 1) ? $clog2(LANE) : 1
)(
   input  logic [AW-1:0]            base_i,
   input  logic [AW-1:0]            stride_i,
   input  logic [CW-1:0]            cnt_i,
   input  logic [VW-1:0]            vlen_i,
   input  logic [LANE-1:0]          mask_i,
   input  logic                     vec_i,
   output logic [LPC-1:0][AW-1:0]   addr_o,
   output logic [LPC-1:0][LIW-1:0]  lane_o,
   output logic [LPC-1:0]           act_o
);

   logic [AW-1:0]          stride_eff;
   logic [LPC-1:0][CW-1:0] idx;

`ifdef SCR1_VMEM_STRIDE_EN
   assign stride_eff = stride_i;
`else
   logic unused_stride;
   assign unused_stride = ^stride_i;
   assign stride_eff    = AW'(1);
`endif

   // Per-slot lane index, wrapped address and activity (scalar: slot 0 only)
   always_comb begin
      idx    = '0;
      addr_o = '0;
      lane_o = '0;
      act_o  = '0;
      for (int j = 0; j < LPC; j++) begin
         idx[j]    = cnt_i + CW'(j);
         lane_o[j] = idx[j][LIW-1:0];
         addr_o[j] = base_i + AW'(idx[j]) * stride_eff;
         act_o[j]  = vec_i ? ((idx[j] < CW'(vlen_i)) && mask_i[lane_o[j]])
                           : (idx[j] == '0);
      end
   end

endmodule

// File: rtl/scr1_vmem_dp_banked.sv
// Dual-port TCM: port A scalar fetch (1-cycle read), port B valid/ready LSU
// port for scalar byte-enabled or masked/strided vector ops, LPC lanes/cycle.
// SCR1_VMEM_STRIDE_EN (in scr1_vmem_addr_gen) enables non-unit lane stride.
module scr1_vmem_dp_banked
   import scr1_vmem_pkg::*;
#(
   parameter int SCR1_WIDTH  = SCR1_VMEM_WIDTH_DEF,
   parameter int SCR1_SIZE   = 65536,
   parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
   parameter int LANE        = SCR1_VMEM_LANE_DEF,
   parameter int LPC         = SCR1_VMEM_LPC_DEF,
   parameter int AW          = $clog2(SCR1_SIZE) - 2
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a_req,
   input  logic [AW-1:0]              a_addr,
   output logic                       a_rvalid,
   output logic [SCR1_WIDTH-1:0]      a_rdata,
   input  logic                       b_req,
   output logic                       b_ready,
   input  logic                       b_we,
   input  logic                       b_vec,
   input  logic [SCR1_NBYTES-1:0]     b_be,
   input  logic [AW-1:0]              b_addr,
   input  logic [AW-1:0]              b_stride,
   input  logic [$clog2(LANE):0]      b_vlen,
   input  logic [LANE-1:0]            b_mask,
   input  logic [LANE*SCR1_WIDTH-1:0] b_wdata,
   output logic                       b_rvalid,
   output logic [LANE*SCR1_WIDTH-1:0] b_rdata,
   output logic                       b_busy
);

   localparam int VW    = $clog2(LANE) + 1;
   localparam int CW    = VW + 1;
   localparam int LIW   = (LANE > 1) ? $clog2(LANE) : 1;
   localparam int DEPTH = 2 ** AW;

   logic [SCR1_WIDTH-1:0]             mem_q [DEPTH];
   vmem_state_e                       state_q;
   logic [CW-1:0]                     cnt_q, cnt_d;
   logic                              we_q, vec_q, last;
   logic [SCR1_NBYTES-1:0]            be_q;
   logic [AW-1:0]                     base_q, stride_q;
   logic [VW-1:0]                     vlen_q, vlen_in;
   logic [LANE-1:0]                   mask_q;
   logic [LANE-1:0][SCR1_WIDTH-1:0]   wdata_q, rdata_q;
   logic                              rvalid_q, ready_q, busy_q;
   logic                              a_rvalid_q;
   logic [SCR1_WIDTH-1:0]             a_rdata_q;
   logic [LPC-1:0][AW-1:0]            lane_addr;
   logic [LPC-1:0][LIW-1:0]           lane_idx;
   logic [LPC-1:0]                    lane_act;

   // vlen of 0 (or anything past LANE) means a full-width op
   assign vlen_in = (b_vlen == '0 || b_vlen > VW'(LANE)) ? VW'(LANE) : b_vlen;
   assign cnt_d   = cnt_q + CW'(LPC);
   assign last    = vec_q ? (cnt_d >= CW'(vlen_q)) : 1'b1;

   scr1_vmem_addr_gen #(
      .AW(AW), .LANE(LANE), .LPC(LPC), .VW(VW), .CW(CW), .LIW(LIW)
   ) u_agen (
      .base_i   (base_q),
      .stride_i (stride_q),
      .cnt_i    (cnt_q),
      .vlen_i   (vlen_q),
      .mask_i   (mask_q),
      .vec_i    (vec_q),
      .addr_o   (lane_addr),
      .lane_o   (lane_idx),
      .act_o    (lane_act)
   );

   // Port B sequencer: latch on accept, LPC lanes per XFER cycle, 1-cycle DONE pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         vec_q    <= 1'b0;
         be_q     <= '0;
         base_q   <= '0;
         stride_q <= '0;
         vlen_q   <= '0;
         mask_q   <= '0;
         wdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (b_req) begin
               we_q     <= b_we;
               vec_q    <= b_vec;
               be_q     <= b_be;
               base_q   <= b_addr;
               stride_q <= b_stride;
               vlen_q   <= vlen_in;
               mask_q   <= b_mask;
               wdata_q  <= b_wdata;
               cnt_q    <= '0;
               rdata_q  <= '0;
               ready_q  <= 1'b0;
               busy_q   <= 1'b1;
               state_q  <= XFER;
            end
            XFER: begin
               // Reads sample the array before this edge's writes land
               for (int j = 0; j < LPC; j++)
                  if (lane_act[j] && !we_q) rdata_q[lane_idx[j]] <= mem_q[lane_addr[j]];
               cnt_q <= cnt_d;
               if (last) begin
                  rvalid_q <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               rvalid_q <= 1'b0;
               ready_q  <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Array writes; later slots override earlier ones on address collision
   always_ff @(posedge clk) begin
      if (state_q == XFER && we_q) begin
         for (int j = 0; j < LPC; j++) begin
            if (lane_act[j]) begin
               if (vec_q) mem_q[lane_addr[j]] <= wdata_q[lane_idx[j]];
               else
                  for (int k = 0; k < SCR1_NBYTES; k++)
                     if (be_q[k]) mem_q[lane_addr[j]][8*k +: 8] <= wdata_q[0][8*k +: 8];
            end
         end
      end
   end

   // Port A fetch: registered read, returns pre-write data on a same-cycle B write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
      end else begin
         a_rvalid_q <= a_req;
         if (a_req) a_rdata_q <= mem_q[a_addr];
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign a_rdata  = a_rdata_q;
   assign b_ready  = ready_q;
   assign b_busy   = busy_q;
   assign b_rvalid = rvalid_q;
   assign b_rdata  = rdata_q;

endmodule

// File: tb/tb_scr1_vmem_dp_banked.sv
// Directed bench for scr1_vmem_dp_banked with a transaction-level memory model.
module tb_scr1_vmem_dp_banked;

   localparam int AW = 14, W = 32, LANE = 8, LPC = 2, DEPTH = 16384;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              a_req = 1'b0;
   logic [AW-1:0]     a_addr = '0;
   logic              a_rvalid;
   logic [W-1:0]      a_rdata;
   logic              b_req = 1'b0, b_we = 1'b0, b_vec = 1'b0;
   logic              b_ready, b_rvalid, b_busy;
   logic [3:0]        b_be = '0;
   logic [AW-1:0]     b_addr = '0, b_stride = '0;
   logic [3:0]        b_vlen = '0;
   logic [LANE-1:0]   b_mask = '0;
   logic [LANE*W-1:0] b_wdata = '0;
   logic [LANE*W-1:0] b_rdata;

   int n_chk = 0, n_err = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   scr1_vmem_dp_banked dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_addr(a_addr), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_ready(b_ready), .b_we(b_we), .b_vec(b_vec), .b_be(b_be),
      .b_addr(b_addr), .b_stride(b_stride), .b_vlen(b_vlen), .b_mask(b_mask),
      .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_busy(b_busy)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit [31:0]       mem_m [DEPTH];
   bit              m_busy = 1'b0;
   int              m_cnt = 0, m_n = 0;
   bit              op_we, op_vec;
   bit [3:0]        op_be;
   bit [7:0]        op_act;
   int              op_addr [LANE];
   bit [7:0][31:0]  op_wd;
   bit [255:0]      op_rd;
   bit              exp_arv = 1'b0, exp_brv = 1'b0;
   bit [31:0]       exp_ard = '0;
   bit [255:0]      exp_brd = '0;

   // Commit the op's writes for lanes below 'lanes' in ascending lane order
   task automatic apply_wr(input int lanes);
      if (op_we)
         for (int i = 0; i < LANE; i++)
            if (op_act[i] && i < lanes) begin
               if (op_vec) mem_m[op_addr[i]] = op_wd[i];
               else
                  for (int k = 0; k < 4; k++)
                     if (op_be[k]) mem_m[op_addr[i]][8*k +: 8] = op_wd[0][8*k +: 8];
            end
   endtask

   initial begin : model
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            if (m_busy && m_cnt < m_n) apply_wr(LPC * m_cnt);
            m_busy = 0; m_cnt = 0;
            exp_arv = 0; exp_ard = '0; exp_brv = 0; exp_brd = '0;
         end else begin
            exp_arv = a_req;
            if (a_req) exp_ard = mem_m[a_addr];
            if (m_busy) begin
               m_cnt++;
               if (m_cnt == m_n) begin
                  apply_wr(LANE);
                  exp_brv = 1; exp_brd = op_rd;
               end else if (m_cnt == m_n + 1) begin
                  exp_brv = 0; m_busy = 0;
               end
            end else if (b_req) begin : accept
               int vl, se;
               vl = (b_vlen == 0 || b_vlen > LANE) ? LANE : int'(b_vlen);
`ifdef SCR1_VMEM_STRIDE_EN
               se = int'(b_stride);
`else
               se = 1;
`endif
               op_we = b_we; op_vec = b_vec; op_be = b_be; op_wd = b_wdata; op_rd = '0;
               m_n = b_vec ? (vl + LPC - 1) / LPC : 1;
               for (int i = 0; i < LANE; i++) begin
                  op_act[i]  = b_vec ? (i < vl && b_mask[i]) : (i == 0);
                  op_addr[i] = b_vec ? (int'(b_addr) + i * se) % DEPTH : int'(b_addr);
                  if (op_act[i] && !b_we) op_rd[32*i +: 32] = mem_m[op_addr[i]];
               end
               m_busy = 1; m_cnt = 0; exp_brd = '0;
            end
         end
      end
   end

   initial begin : cmp
      forever begin
         @(negedge clk);
         if (started) begin
            chk("a_rvalid", a_rvalid, exp_arv);
            chk("a_rdata", a_rdata, exp_ard);
            chk("b_ready", b_ready, !m_busy);
            chk("b_busy", b_busy, m_busy);
            chk("b_rvalid", b_rvalid, exp_brv);
            if (exp_brv || !m_busy) chk("b_rdata", b_rdata, exp_brd);
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic b_op(input bit we, input bit vec, input bit [3:0] be, input int addr,
                       input int stride, input int vlen, input bit [7:0] mask,
                       input bit [255:0] wd, output bit [255:0] rd, output int lat);
      int k;
      @(negedge clk);
      b_we = we; b_vec = vec; b_be = be; b_addr = AW'(addr); b_stride = AW'(stride);
      b_vlen = 4'(vlen); b_mask = mask; b_wdata = wd; b_req = 1'b1;
      k = 0;
      while (!b_ready && k < 20) begin @(negedge clk); k++; end
      chk("b_accept_wait", b_ready, 1'b1);
      @(negedge clk);
      b_req = 1'b0; lat = 1;
      while (!b_rvalid && lat < 40) begin @(negedge clk); lat++; end
      chk("b_done_wait", b_rvalid, 1'b1);
      rd = b_rdata;
   endtask

   task automatic a_fetch(input int addr, output bit [31:0] d);
      @(negedge clk);
      a_req = 1'b1; a_addr = AW'(addr);
      @(negedge clk);
      a_req = 1'b0; d = a_rdata;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish by 500000ns want finish");
      $fatal(1);
   end

   initial begin : stim
      bit [255:0] wd, rd;
      bit [31:0]  d;
      int         lat;
      @(posedge clk);
      started = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_b_ready", b_ready, 1'b1);
      chk("reset_b_rdata", b_rdata, '0);
      #2 rst_n = 1'b1;

      // 1: scalar byte-merged write over a zeroed word
      b_op(1, 0, 4'hF, 'h10, 0, 0, 8'h00, '0, rd, lat);
      b_op(1, 0, 4'b0101, 'h10, 0, 0, 8'h00, 256'hA5A5_A5A5, rd, lat);
      chk("t1_wr_latency", lat, 2);
      b_op(0, 0, 4'h0, 'h10, 0, 0, 8'h00, '0, rd, lat);
      chk("t1_rd_lane0", rd[31:0], 32'h00A5_00A5);

      // 2: full vector write, lane i = i+1, then fetch through port A
      for (int i = 0; i < LANE; i++) wd[32*i +: 32] = 32'(i + 1);
      b_op(1, 1, 4'h0, 'h20, 1, 8, 8'hFF, wd, rd, lat);
      chk("t2_latency", lat, 5);
      for (int i = 0; i < LANE; i++) begin
         a_fetch('h20 + i, d);
         chk("t2_fetch", d, 32'(i + 1));
      end

      // 3: strided read across the top of memory
      b_op(1, 0, 4'hF, 'h3FFE, 0, 0, 8'h00, 256'h11, rd, lat);
      b_op(1, 0, 4'hF, 'h3FFF, 0, 0, 8'h00, 256'h22, rd, lat);
      b_op(1, 0, 4'hF, 'h0000, 0, 0, 8'h00, 256'h33, rd, lat);
      b_op(1, 0, 4'hF, 'h0001, 0, 0, 8'h00, 256'h44, rd, lat);
      b_op(1, 0, 4'hF, 'h0004, 0, 0, 8'h00, 256'h55, rd, lat);
      b_op(1, 0, 4'hF, 'h0007, 0, 0, 8'h00, 256'h66, rd, lat);
      b_op(0, 1, 4'h0, 'h3FFE, 3, 4, 8'h0F, '0, rd, lat);
      chk("t3_latency", lat, 3);
`ifdef SCR1_VMEM_STRIDE_EN
      chk("t3_lanes", rd, {128'h0, 32'h66, 32'h55, 32'h44, 32'h11});
`else
      chk("t3_lanes", rd, {128'h0, 32'h44, 32'h33, 32'h22, 32'h11});
`endif

      // 4: masked write / masked read; vlen 0 preload means all 8 lanes
      for (int i = 0; i < LANE; i++) wd[32*i +: 32] = 32'(8'hC0 + i);
      b_op(1, 1, 4'h0, 'h50, 1, 0, 8'hFF, wd, rd, lat);
      chk("t4_vlen0_latency", lat, 5);
      for (int i = 0; i < LANE; i++) wd[32*i +: 32] = 32'(8'hB0 + i);
      b_op(1, 1, 4'h0, 'h50, 1, 6, 8'h0F, wd, rd, lat);
      chk("t4_wr_latency", lat, 4);
      b_op(0, 1, 4'h0, 'h50, 1, 6, 8'h30, '0, rd, lat);
      chk("t4_rd_mask30", rd, {64'h0, 32'hC5, 32'hC4, 128'h0});
      b_op(0, 1, 4'h0, 'h50, 1, 6, 8'hFF, '0, rd, lat);
      chk("t4_rd_maskFF", rd, {64'h0, 32'hC5, 32'hC4, 32'hB3, 32'hB2, 32'hB1, 32'hB0});

      // 5: port A read of a word in the same cycle port B writes it
      b_op(1, 0, 4'hF, 'h40, 0, 0, 8'h00, 256'h1111_1111, rd, lat);
      @(negedge clk);
      b_we = 1'b1; b_vec = 1'b0; b_be = 4'hF; b_addr = AW'('h40);
      b_wdata = 256'h2222_2222; b_req = 1'b1;
      @(negedge clk);
      b_req = 1'b0; a_req = 1'b1; a_addr = AW'('h40);
      @(negedge clk);
      chk("t5_a_old", a_rdata, 32'h1111_1111);
      @(negedge clk);
      a_req = 1'b0;
      chk("t5_a_new", a_rdata, 32'h2222_2222);

      // 6: reset during a vector write after two XFER cycles
      b_op(1, 1, 4'h0, 'h60, 1, 8, 8'hFF, '0, rd, lat);
      for (int i = 0; i < LANE; i++) wd[32*i +: 32] = 32'(8'hD0 + i);
      @(negedge clk);
      b_we = 1'b1; b_vec = 1'b1; b_addr = AW'('h60); b_stride = AW'(1);
      b_vlen = 4'd8; b_mask = 8'hFF; b_wdata = wd; b_req = 1'b1;
      @(negedge clk);
      b_req = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_ready", b_ready, 1'b1);
      chk("t6_rst_busy", b_busy, 1'b0);
      chk("t6_rst_rvalid", b_rvalid, 1'b0);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      a_fetch('h63, d);
      chk("t6_lane3_kept", d, 32'hD3);
      a_fetch('h64, d);
      chk("t6_lane4_unwritten", d, 32'h0);
      b_op(0, 1, 4'h0, 'h60, 1, 8, 8'hFF, '0, rd, lat);
      chk("t6_after_latency", lat, 5);
      chk("t6_after_lanes", rd, {128'h0, 32'hD3, 32'hD2, 32'hD1, 32'hD0});

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
